riscv_multicycle: RTL and testbench

Parametrised multi-cycle successor to the single-cycle RV32I datapath: one instruction is fetched, decoded, executed, optionally memory-accessed and written back over several clock cycles by an explicit control FSM. Instruction and data memories sit outside the block behind req/ready handshakes, so wait-state memories are supported. The block sits at the top of the CPU hierarchy, in place of the single-cycle core, and owns the PC, instruction register, register file and ALU.

---
 rtl/riscv_multicycle_if.sv | 27 ++
 rtl/riscv_multicycle.sv | 194 +++++++++++++++++++
 tb/tb_riscv_multicycle.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_multicycle_if.sv
// Instruction and data memory request/ready buses of the multi-cycle RV32I/RV64I core.
interface riscv_multicycle_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr, input imem_ready, imem_rdata,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, output imem_ready, imem_rdata,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/riscv_multicycle.sv
// Multi-cycle RV32I/RV64I subset core: FETCH/DECODE/EXEC/MEM/WB control FSM, register file
// and ALU, with instruction and data memories behind req/ready handshakes.
module riscv_multicycle #(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   riscv_multicycle_if.master      bus,
   output logic                    retire,
   output logic                    halt,
   input  logic [$clog2(NREG)-1:0] dbg_raddr,
   output logic [XLEN-1:0]         dbg_rdata
);
   localparam int unsigned RW     = $clog2(NREG);
   localparam int unsigned SW     = $clog2(XLEN);
   localparam logic [2:0]  F3_MEM = (XLEN == 64) ? 3'b011 : 3'b010;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
   typedef enum logic [2:0] {
      OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_ILLEGAL
   } op_e;

   state_e          state;
   logic [31:0]     ir;
   logic [XLEN-1:0] pc, a, b, imm, aluout, mdr, target;
   logic            imem_req, dmem_req, dmem_we;
   logic [XLEN-1:0] dmem_addr, dmem_wdata;
   logic [XLEN-1:0] regs [NREG];

   logic [6:0]    opcode, f7;
   logic [2:0]    f3;
   logic [RW-1:0] rd, rs1, rs2;
   assign opcode = ir[6:0];
   assign f3     = ir[14:12];
   assign f7     = ir[31:25];
   assign rd     = ir[7 +: RW];
   assign rs1    = ir[15 +: RW];
   assign rs2    = ir[20 +: RW];

   assign bus.imem_req   = imem_req;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = dmem_req;
   assign bus.dmem_we    = dmem_we;
   assign bus.dmem_addr  = dmem_addr;
   assign bus.dmem_wdata = dmem_wdata;

   // Debug port sees the pre-write value when a writeback lands on the same edge.
   assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];

   // Instruction class and immediate, decoded from the held IR.
   op_e         op;
   logic [31:0] imm32;
   logic [XLEN-1:0] imm_dec;
   always_comb begin
      op = OP_ILLEGAL;
      case (opcode)
         7'b0110011:
            if ((f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20)) ||
                (f3 != 3'b000 && f3 != 3'b011 && f7 == 7'h00)) op = OP_ALU_R;
         7'b0010011:
            if (f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b100 ||
                f3 == 3'b110 || f3 == 3'b111) op = OP_ALU_I;
         7'b0000011: if (f3 == F3_MEM) op = OP_LOAD;
         7'b0100011: if (f3 == F3_MEM) op = OP_STORE;
         7'b1100011: if (f3 == 3'b000 || f3 == 3'b001) op = OP_BRANCH;
         7'b1101111: op = OP_JAL;
         default: op = OP_ILLEGAL;
      endcase

      case (op)
         OP_STORE:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OP_BRANCH: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OP_JAL:    imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:   imm32 = {{20{ir[31]}}, ir[31:20]};
      endcase
      imm_dec = XLEN'($signed(imm32));
   end

   logic [XLEN-1:0] alu_b, alu_res;
   logic [SW-1:0]   shamt;
   logic            taken;
   always_comb begin
      alu_b = (op == OP_ALU_R) ? b : imm;
      shamt = alu_b[SW-1:0];
      case (f3)
         3'b000:  alu_res = (op == OP_ALU_R && f7[5]) ? a - alu_b : a + alu_b;
         3'b001:  alu_res = a << shamt;
         3'b010:  alu_res = ($signed(a) < $signed(alu_b)) ? XLEN'(1) : '0;
         3'b100:  alu_res = a ^ alu_b;
         3'b101:  alu_res = a >> shamt;
         3'b110:  alu_res = a | alu_b;
         3'b111:  alu_res = a & alu_b;
         default: alu_res = a + alu_b;
      endcase
      taken = (f3 == 3'b000) ? (a == b) : (a != b);
   end

   // Control FSM with datapath registers; every request/status output is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         a          <= '0;
         b          <= '0;
         imm        <= '0;
         aluout     <= '0;
         mdr        <= '0;
         target     <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         retire     <= 1'b0;
         halt       <= 1'b0;
         for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
      end else begin
         retire <= 1'b0;
         case (state)
            S_FETCH: begin
               if (imem_req && bus.imem_ready) begin
                  ir       <= bus.imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else begin
                  imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               if (op == OP_ILLEGAL) begin
                  halt  <= 1'b1;
                  state <= S_HALT;
               end else begin
                  a     <= regs[rs1];
                  b     <= regs[rs2];
                  imm   <= imm_dec;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               aluout <= alu_res;
               case (op)
                  OP_BRANCH: begin
                     pc       <= taken ? pc + imm : pc + XLEN'(4);
                     retire   <= 1'b1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end
                  OP_JAL: begin
                     aluout <= pc + XLEN'(4);
                     target <= pc + imm;
                     state  <= S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     dmem_addr  <= a + imm;
                     dmem_wdata <= b;
                     dmem_we    <= (op == OP_STORE);
                     dmem_req   <= 1'b1;
                     state      <= S_MEM;
                  end
                  default: state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (dmem_we) begin
                     pc       <= pc + XLEN'(4);
                     retire   <= 1'b1;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     mdr   <= bus.dmem_rdata;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (rd != '0) regs[rd] <= (op == OP_LOAD) ? mdr : aluout;
               pc       <= (op == OP_JAL) ? target : pc + XLEN'(4);
               retire   <= 1'b1;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_riscv_multicycle.sv
// Self-checking bench for riscv_multicycle: directed program scenarios plus a randomized
// ALU program compared against an instruction-level reference model.
module tb_riscv_multicycle;
   localparam int unsigned XLEN = 32;
   localparam logic [31:0] ECALL = 32'h0000_0073;
   localparam logic [6:0]  OPI = 7'b0010011;

   logic        clk = 1'b0;
   logic        reset;
   logic        retire, halt;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;

   riscv_multicycle_if #(.XLEN(XLEN)) bus ();

   riscv_multicycle #(.XLEN(XLEN), .NREG(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .bus(bus), .retire(retire), .halt(halt),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: programmable wait states, data memory re-seeded on reset.
   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   int          iwait = 0, dwait = 0, icnt, dcnt;
   logic [31:0] st_addr, st_data;

   assign bus.imem_ready = bus.imem_req && (icnt >= iwait);
   assign bus.imem_rdata = imem[bus.imem_addr[7:2]];
   assign bus.dmem_ready = bus.dmem_req && (dcnt >= dwait);
   assign bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         icnt    <= 0;
         dcnt    <= 0;
         st_addr <= '0;
         st_data <= '0;
         for (int i = 0; i < 64; i++) dmem[i] <= (i == 3) ? 32'hDEAD_BEEF : 32'h0000_0055;
      end else begin
         icnt <= (bus.imem_req && !bus.imem_ready) ? icnt + 1 : 0;
         dcnt <= (bus.dmem_req && !bus.dmem_ready) ? dcnt + 1 : 0;
         if (bus.dmem_req && bus.dmem_ready && bus.dmem_we) begin
            dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
            st_addr <= bus.dmem_addr;
            st_data <= bus.dmem_wdata;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
      dbg_raddr = 5'(idx);
      #1;
      check(tag, dbg_rdata, exp);
   endtask

   // Cycles from the current sample point to the next retire pulse, bounded.
   task automatic next_retire(input string tag, input int exp_cycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!retire && n < 100);
      check(tag, 32'(n), 32'(exp_cycles));
   endtask

   task automatic wait_halt(input string tag);
      int n;
      n = 0;
      while (!halt && n < 30) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(halt), 32'd1);
   endtask

   // Pulse reset; on return the first fetch request is already up.
   task automatic restart();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = ECALL;
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
      return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
      logic [11:0] v;
      v = 12'(imm);
      return {v, 5'(rs1), f3, 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [11:0] v;
      v = 12'(imm);
      return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
      logic [12:0] v;
      v = 13'(imm);
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [20:0] v;
      v = 21'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
   endfunction

   typedef enum int {
      M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL,
      M_ADDI, M_ANDI, M_ORI, M_XORI, M_SLTI
   } mnem_e;

   // Reference semantics of one ALU instruction, straight from the ISA definition.
   function automatic logic [31:0] ref_alu(input mnem_e m, input logic [31:0] x,
                                           input logic [31:0] y);
      case (m)
         M_ADD, M_ADDI: return x + y;
         M_SUB:         return x - y;
         M_AND, M_ANDI: return x & y;
         M_OR,  M_ORI:  return x | y;
         M_XOR, M_XORI: return x ^ y;
         M_SLT, M_SLTI: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         M_SLL:         return x << y[4:0];
         M_SRL:         return x >> y[4:0];
         default:       return 32'hx;
      endcase
   endfunction

   function automatic logic [31:0] encode(input mnem_e m, input int rd, input int rs1,
                                          input int rs2, input int imm);
      case (m)
         M_ADD:   return enc_r(7'h00, rs2, rs1, 3'b000, rd);
         M_SUB:   return enc_r(7'h20, rs2, rs1, 3'b000, rd);
         M_SLL:   return enc_r(7'h00, rs2, rs1, 3'b001, rd);
         M_SLT:   return enc_r(7'h00, rs2, rs1, 3'b010, rd);
         M_XOR:   return enc_r(7'h00, rs2, rs1, 3'b100, rd);
         M_SRL:   return enc_r(7'h00, rs2, rs1, 3'b101, rd);
         M_OR:    return enc_r(7'h00, rs2, rs1, 3'b110, rd);
         M_AND:   return enc_r(7'h00, rs2, rs1, 3'b111, rd);
         M_ADDI:  return enc_i(imm, rs1, 3'b000, rd, OPI);
         M_SLTI:  return enc_i(imm, rs1, 3'b010, rd, OPI);
         M_XORI:  return enc_i(imm, rs1, 3'b100, rd, OPI);
         M_ORI:   return enc_i(imm, rs1, 3'b110, rd, OPI);
         default: return enc_i(imm, rs1, 3'b111, rd, OPI);
      endcase
   endfunction

   logic [31:0] model [8];

   initial begin
      int reqs;
      reset     = 1'b1;
      dbg_raddr = '0;

      // Scenario 1: three ALU instructions, zero-wait memories, then ECALL halt.
      clear_imem();
      imem[0] = enc_i(5, 0, 3'b000, 1, OPI);
      imem[1] = enc_i(-3, 0, 3'b000, 2, OPI);
      imem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
      @(negedge clk);
      check("rst imem_req", 32'(bus.imem_req), 32'd0);
      check("rst dmem_req", 32'(bus.dmem_req), 32'd0);
      check("rst dmem_we", 32'(bus.dmem_we), 32'd0);
      check("rst retire", 32'(retire), 32'd0);
      check("rst halt", 32'(halt), 32'd0);
      check("rst imem_addr", bus.imem_addr, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("req after reset", 32'(bus.imem_req), 32'd1);
      next_retire("addi x1 cycles", 4);
      next_retire("addi x2 cycles", 4);
      next_retire("add x3 cycles", 4);
      check_reg("x1", 1, 32'd5);
      check_reg("x2", 2, 32'hFFFF_FFFD);
      check_reg("x3", 3, 32'd2);
      wait_halt("ecall halts");
      reqs = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.imem_req || retire) reqs++;
      end
      check("no activity while halted", 32'(reqs), 32'd0);
      check("halt sticky", 32'(halt), 32'd1);

      // Scenario 2: store then load with three data wait states.
      imem[3] = enc_s(8, 3, 0);
      imem[4] = enc_i(8, 0, 3'b010, 4, 7'b0000011);
      dwait   = 3;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset clears halt", 32'(halt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("resume addr", bus.imem_addr, 32'h0);
      check("resume req", 32'(bus.imem_req), 32'd1);
      next_retire("s2 addi x1", 4);
      next_retire("s2 addi x2", 4);
      next_retire("s2 add x3", 4);
      next_retire("sw cycles", 7);
      check("sw addr", st_addr, 32'd8);
      check("sw data", st_data, 32'd2);
      check("sw memory", dmem[2], 32'd2);
      next_retire("lw cycles", 8);
      check_reg("lw x4", 4, 32'd2);
      wait_halt("s2 halt");

      // Scenario 3: branches at 0x10/0x18, JAL forward and backward, write to x0.
      clear_imem();
      dwait   = 0;
      imem[0] = enc_i(1, 0, 3'b000, 1, OPI);
      imem[1] = enc_i(7, 0, 3'b000, 0, OPI);
      imem[2] = enc_i(7, 0, 3'b000, 0, OPI);
      imem[3] = enc_i(7, 0, 3'b000, 0, OPI);
      imem[4] = enc_b(8, 1, 1, 3'b000);
      imem[6] = enc_b(8, 1, 1, 3'b001);
      imem[7] = enc_j(36, 0);
      imem[16] = enc_j(-16, 5);
      restart();
      repeat (4) next_retire("s3 addi", 4);
      check_reg("x0 reads zero", 0, 32'd0);
      next_retire("beq cycles", 3);
      check("beq target", bus.imem_addr, 32'h18);
      next_retire("bne cycles", 3);
      check("bne fallthrough", bus.imem_addr, 32'h1C);
      next_retire("jal fwd cycles", 4);
      check("jal fwd target", bus.imem_addr, 32'h40);
      next_retire("jal back cycles", 4);
      check("jal back target", bus.imem_addr, 32'h30);
      check_reg("jal link x5", 5, 32'h44);
      wait_halt("s3 halt");

      // Scenario 4: reset while a load is waiting on dmem_ready.
      clear_imem();
      imem[0] = enc_i(9, 0, 3'b000, 6, OPI);
      imem[1] = enc_i(12, 0, 3'b010, 7, 7'b0000011);
      dwait   = 10;
      restart();
      next_retire("s4 addi x6", 4);
      reqs = 0;
      while (!bus.dmem_req && reqs < 20) begin
         @(negedge clk);
         reqs++;
      end
      repeat (2) @(negedge clk);
      check("dmem_req pending", 32'(bus.dmem_req), 32'd1);
      reset = 1'b1;
      #1;
      check("dmem_req aborted", 32'(bus.dmem_req), 32'd0);
      check("dmem_we aborted", 32'(bus.dmem_we), 32'd0);
      check_reg("x7 not written", 7, 32'd0);
      check_reg("x6 cleared", 6, 32'd0);
      @(negedge clk);
      dwait = 0;
      reset = 1'b0;
      @(negedge clk);
      check("restart addr", bus.imem_addr, 32'h0);
      check("restart req", 32'(bus.imem_req), 32'd1);
      next_retire("s4 addi again", 4);
      next_retire("s4 lw cycles", 5);
      check_reg("x6 after rerun", 6, 32'd9);
      check_reg("x7 loaded", 7, 32'hDEAD_BEEF);
      wait_halt("s4 halt");

      // Scenario 5: random ALU program with one instruction wait state vs. reference model.
      clear_imem();
      iwait = 1;
      for (int r = 0; r < 8; r++) model[r] = 32'd0;
      for (int r = 1; r < 8; r++) begin
         int imm;
         imm = int'($urandom_range(0, 4095)) - 2048;
         imem[r - 1] = encode(M_ADDI, r, 0, 0, imm);
         model[r] = ref_alu(M_ADDI, model[0], 32'(imm));
      end
      for (int k = 7; k < 31; k++) begin
         mnem_e m;
         int rd, rs1, rs2, imm;
         logic [31:0] res;
         m   = mnem_e'($urandom_range(0, 12));
         rd  = int'($urandom_range(0, 7));
         rs1 = int'($urandom_range(0, 7));
         rs2 = int'($urandom_range(0, 7));
         imm = int'($urandom_range(0, 4095)) - 2048;
         imem[k] = encode(m, rd, rs1, rs2, imm);
         res = ref_alu(m, model[rs1], (m <= M_SRL) ? model[rs2] : 32'(imm));
         if (rd != 0) model[rd] = res;
      end
      restart();
      for (int k = 0; k < 31; k++) next_retire("rand alu cycles", 5);
      for (int r = 0; r < 8; r++) check_reg("rand reg", r, model[r]);
      wait_halt("s5 halt");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
